// File: rtl/addr_seq.sv
// addr_seq: walks [base..limit] with a programmable stride in WRAP, ONESHOT or PINGPONG mode,
// handing each address to a consumer over a valid/ready handshake.
module addr_seq #(
  parameter int MAX_DATA = 256,
  localparam int AWIDTH = $clog2(MAX_DATA)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [AWIDTH-1:0] base,
  input  logic [AWIDTH-1:0] limit,
  input  logic [AWIDTH-1:0] stride,
  output logic [AWIDTH-1:0] addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              pass_end,
  output logic              done,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state;
  logic [1:0] mode_r;
  logic [AWIDTH-1:0] base_r, lim_r, stride_r, cb, cl, cs, nxt, dif;
  logic [AWIDTH:0] sum;
  logic dir, up_ok, dn_ok, pp, rev, pend, acc;
  function automatic logic [AWIDTH-1:0] clamp(input logic [AWIDTH-1:0] v);
    return ({1'b0, v} > (AWIDTH+1)'(MAX_DATA - 1)) ? AWIDTH'(MAX_DATA - 1) : v;
  endfunction
  assign cb = clamp(base);
  assign cl = clamp(limit) < cb ? cb : clamp(limit);
  assign cs = clamp(stride) == '0 ? AWIDTH'(1) : clamp(stride);
  // one extra bit keeps addr+stride from wrapping past the top of the address space
  assign sum = {1'b0, addr} + {1'b0, stride_r};
  assign dif = addr - stride_r;
  assign up_ok = sum <= {1'b0, lim_r};
  assign dn_ok = {1'b0, addr} >= {1'b0, base_r} + {1'b0, stride_r};
  assign pp = mode_r == 2'b10;
  assign rev = pp && (dir ? !dn_ok : !up_ok);
  assign pend = pp ? rev : !up_ok;
  assign acc = addr_valid && addr_ready;
  assign nxt = !pp ? (up_ok ? sum[AWIDTH-1:0] : base_r) :
               dir ? (dn_ok ? dif : (up_ok ? sum[AWIDTH-1:0] : lim_r)) :
                     (up_ok ? sum[AWIDTH-1:0] : (dn_ok ? dif : base_r));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      addr_valid <= 1'b0;
      pass_end <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
      dir <= 1'b0;
      mode_r <= 2'b00;
      base_r <= '0;
      lim_r <= '0;
      stride_r <= AWIDTH'(1);
    end else if (abort) begin
      state <= IDLE;
      addr_valid <= 1'b0;
      pass_end <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pass_end <= 1'b0;
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            mode_r <= mode;
            base_r <= cb;
            lim_r <= cl;
            stride_r <= cs;
            addr <= cb;
            dir <= 1'b0;
            addr_valid <= 1'b1;
            busy <= 1'b1;
          end
        end
        RUN: begin
          pass_end <= acc && pend;
          done <= 1'b0;
          if (acc && mode_r == 2'b01 && pend) begin
            state <= FIN;
            addr_valid <= 1'b0;
            done <= 1'b1;
          end else if (acc) begin
            addr <= nxt;
            dir <= dir ^ rev;
          end
        end
        default: begin
          state <= IDLE;
          pass_end <= 1'b0;
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_addr_seq.sv
// tb_addr_seq: directed and random stimulus against an integer-arithmetic model of the sequencer.
module tb_addr_seq;
  localparam int MD = 256;
  localparam int AW = $clog2(MD);
  logic clk = 0, rst_n = 0, start = 0, abort = 0, addr_ready = 0;
  logic [1:0] mode = 0;
  logic [AW-1:0] base = 0, limit = 0, stride = 0;
  logic [AW-1:0] addr;
  logic addr_valid, pass_end, done, busy;
  int checks = 0, errors = 0;
  int m_st, m_addr, m_dir, m_b, m_l, m_s, m_mode;
  bit m_valid, m_pe, m_done;
  addr_seq #(.MAX_DATA(MD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .base(base), .limit(limit), .stride(stride), .addr(addr), .addr_valid(addr_valid),
    .addr_ready(addr_ready), .pass_end(pass_end), .done(done), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic int clampv(int v);
    return v > MD - 1 ? MD - 1 : v;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic check_all(string t);
    chk({t, ".addr"}, 32'(addr), m_addr);
    chk({t, ".valid"}, 32'(addr_valid), 32'(m_valid));
    chk({t, ".pass_end"}, 32'(pass_end), 32'(m_pe));
    chk({t, ".done"}, 32'(done), 32'(m_done));
    chk({t, ".busy"}, 32'(busy), 32'(m_st != 0));
  endtask
  task automatic model_reset();
    m_st = 0; m_addr = 0; m_valid = 0; m_pe = 0; m_done = 0; m_dir = 1;
  endtask
  // Next address from the window rules: step, and on overshoot either restart or bounce.
  task automatic succ(output int nx, output bit e);
    int t;
    if (m_mode != 2) begin
      t = m_addr + m_s;
      e = t > m_l;
      nx = e ? m_b : t;
    end else begin
      t = m_addr + m_dir * m_s;
      e = t < m_b || t > m_l;
      if (e) begin
        m_dir = -m_dir;
        t = m_addr + m_dir * m_s;
        t = t < m_b ? m_b : (t > m_l ? m_l : t);
      end
      nx = t;
    end
  endtask
  task automatic tick(string t);
    int nx;
    bit e;
    @(posedge clk);
    if (abort) begin
      m_st = 0; m_valid = 0; m_pe = 0; m_done = 0;
    end else if (m_st == 0) begin
      m_pe = 0; m_done = 0;
      if (start) begin
        m_b = clampv(int'(base));
        m_l = clampv(int'(limit));
        if (m_l < m_b) m_l = m_b;
        m_s = clampv(int'(stride));
        if (m_s == 0) m_s = 1;
        m_mode = mode == 2'b11 ? 0 : int'(mode);
        m_addr = m_b; m_dir = 1; m_valid = 1; m_st = 1;
      end
    end else if (m_st == 2) begin
      m_st = 0; m_pe = 0; m_done = 0;
    end else begin
      m_pe = 0; m_done = 0;
      if (addr_ready) begin
        succ(nx, e);
        m_pe = e;
        if (m_mode == 1 && e) begin
          m_st = 2; m_valid = 0; m_done = 1;
        end else m_addr = nx;
      end
    end
    #1 check_all(t);
  endtask
  task automatic do_reset(string t);
    rst_n = 0;
    #1 model_reset();
    check_all(t);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask
  task automatic cfg(int md, int b, int l, int s, string t);
    mode = 2'(md); base = AW'(b); limit = AW'(l); stride = AW'(s);
    start = 1;
    tick(t);
    start = 0;
  endtask
  task automatic kill(string t);
    abort = 1;
    tick(t);
    abort = 0;
  endtask
  initial begin
    int pat[4] = '{1, 0, 0, 1};
    model_reset();
    do_reset("reset");
    addr_ready = 1;
    cfg(0, 2, 5, 1, "t1.start");
    chk("t1.first_addr", 32'(addr), 2);
    chk("t1.first_valid", 32'(addr_valid), 1);
    repeat (7) tick("t1");
    kill("t1.abort");
    cfg(1, 0, 9, 4, "t2.start");
    repeat (5) tick("t2");
    cfg(2, 0, 3, 1, "t3.start");
    repeat (10) tick("t3");
    kill("t3.abort");
    cfg(0, 0, 3, 1, "t4.start");
    repeat (3) foreach (pat[i]) begin
      addr_ready = pat[i][0];
      tick("t4");
    end
    kill("t4.abort");
    addr_ready = 1;
    cfg(0, 250, 255, 3, "t5.start");
    chk("t5.a0", 32'(addr), 250);
    tick("t5");
    chk("t5.a1", 32'(addr), 253);
    tick("t5");
    chk("t5.a2", 32'(addr), 250);
    chk("t5.pass_end", 32'(pass_end), 1);
    kill("t5.abort");
    cfg(0, 10, 20, 0, "t6.stride0");
    repeat (4) tick("t6.stride0");
    base = 100; start = 1;
    tick("t6.midstart");
    start = 0;
    tick("t6.midstart");
    kill("t6.abort");
    chk("t6.abort_busy", 32'(busy), 0);
    abort = 1; start = 1;
    tick("t6.abort_vs_start");
    abort = 0; start = 0;
    cfg(1, 30, 5, 7, "t6.limlow");
    repeat (3) tick("t6.limlow");
    cfg(2, 40, 40, 3, "t6.single_pp");
    repeat (3) tick("t6.single_pp");
    kill("t6.abort2");
    cfg(0, 40, 50, 2, "t6.prereset");
    repeat (3) tick("t6.prereset");
    do_reset("t6.reset");
    repeat (600) begin
      int b;
      b = $urandom_range(0, MD - 1);
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 39) == 0);
      addr_ready = ($urandom_range(0, 9) < 7);
      mode = 2'($urandom_range(0, 3));
      base = AW'(b);
      limit = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, MD - 1)) : AW'(clampv(b + $urandom_range(0, 12)));
      stride = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, MD - 1)) : AW'($urandom_range(0, 5));
      if ($urandom_range(0, 199) == 0) do_reset("rnd.reset");
      else tick("rnd");
    end
    start = 0; abort = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
